// File: rtl/inst_queue_pkg.sv
// rtl/inst_queue_pkg.sv - shared constants for the instruction queue and its neighbours
package inst_queue_pkg;

  localparam int          IQ_INST_W = 32;
  localparam logic [31:0] IQ_NOP    = 32'h00000013;

  // Occupancy at which almost_full asserts.
  function automatic int iq_af_level(input int depth, input int margin);
    return depth - margin;
  endfunction

endpackage

// File: rtl/inst_queue_if.sv
// rtl/inst_queue_if.sv - fetch/issue side signals of the instruction queue
interface inst_queue_if import inst_queue_pkg::*; #(
  parameter int INST_W    = IQ_INST_W,
  parameter int DEPTH_LOG = 3
);
  logic              inst_rdy;
  logic [INST_W-1:0] inst;
  logic [INST_W-1:0] pc_in;
  logic              flush;
  logic              deq_en;
  logic              out_valid;
  logic [INST_W-1:0] out_inst;
  logic [INST_W-1:0] out_pc;
  logic              full;
  logic              almost_full;
  logic [DEPTH_LOG:0] count;

  modport master (
    output inst_rdy, inst, pc_in, flush, deq_en,
    input  out_valid, out_inst, out_pc, full, almost_full, count
  );

  modport slave (
    input  inst_rdy, inst, pc_in, flush, deq_en,
    output out_valid, out_inst, out_pc, full, almost_full, count
  );
endinterface

// File: rtl/inst_queue_iq_mem.sv
// rtl/inst_queue_iq_mem.sv - queue storage, one synchronous write port and one asynchronous read port
module iq_mem #(
  parameter int DEPTH_LOG = 3,
  parameter int WIDTH     = 64
) (
  input  logic                 clk,
  input  logic                 we_i,
  input  logic [DEPTH_LOG-1:0] waddr_i,
  input  logic [WIDTH-1:0]     wdata_i,
  input  logic [DEPTH_LOG-1:0] raddr_i,
  output logic [WIDTH-1:0]     rdata_o
);
  logic [WIDTH-1:0] mem_q [2**DEPTH_LOG];

  // Storage is deliberately left out of reset; occupancy lives in the control logic.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/inst_queue.sv
// rtl/inst_queue.sv - circular instruction FIFO between IFetch and decode/issue
module inst_queue import inst_queue_pkg::*; #(
  parameter int DEPTH_LOG = 3,
  parameter int AF_MARGIN = 2,
  parameter int INST_W    = IQ_INST_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rdy,
  inst_queue_if.slave  q
);
  localparam int DEPTH = 2 ** DEPTH_LOG;
  localparam int CNT_W = DEPTH_LOG + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_AF   = CNT_W'(iq_af_level(DEPTH, AF_MARGIN));

  logic [DEPTH_LOG-1:0] head_q, head_d;
  logic [DEPTH_LOG-1:0] tail_q, tail_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 enq, deq, do_flush;
  logic [2*INST_W-1:0]  rdata;

  // Status flags come only from the registered count, never from this cycle's inputs.
  assign q.out_valid   = (count_q != '0);
  assign q.full        = (count_q == CNT_FULL);
  assign q.almost_full = (count_q >= CNT_AF);
  assign q.count       = count_q;

  assign do_flush = rdy && q.flush;
  assign enq      = rdy && q.inst_rdy && !q.full && !q.flush;
  assign deq      = rdy && q.deq_en && q.out_valid && !q.flush;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (do_flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (enq) tail_d = tail_q + 1'b1;
      if (deq) head_d = head_q + 1'b1;
      if (enq && !deq)      count_d = count_q + 1'b1;
      else if (deq && !enq) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  iq_mem #(
    .DEPTH_LOG (DEPTH_LOG),
    .WIDTH     (2*INST_W)
  ) u_iq_mem (
    .clk     (clk),
    .we_i    (enq),
    .waddr_i (tail_q),
    .wdata_i ({q.inst, q.pc_in}),
    .raddr_i (head_q),
    .rdata_o (rdata)
  );

  assign q.out_inst = rdata[2*INST_W-1:INST_W];
  assign q.out_pc   = rdata[INST_W-1:0];
endmodule

// File: tb/tb_inst_queue.sv
// tb/tb_inst_queue.sv - directed self-checking bench for inst_queue
module tb_inst_queue;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rdy = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  inst_queue_if #(.INST_W(32), .DEPTH_LOG(3)) iq ();

  inst_queue #(.DEPTH_LOG(3), .AF_MARGIN(2), .INST_W(32)) u_dut (
    .clk (clk),
    .rst (rst),
    .rdy (rdy),
    .q   (iq.slave)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    iq.inst_rdy = 1'b0;
    iq.flush    = 1'b0;
    iq.deq_en   = 1'b0;
  endtask

  task automatic offer(input logic [31:0] pc);
    iq.inst_rdy = 1'b1;
    iq.pc_in    = pc;
    iq.inst     = 32'hA000_0000 | pc;
  endtask

  initial begin
    idle();
    iq.inst  = 32'h0;
    iq.pc_in = 32'h0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_count", 64'(iq.count), 64'd0);
    chk("rst_valid", 64'(iq.out_valid), 64'd0);
    chk("rst_full", 64'(iq.full), 64'd0);
    chk("rst_af", 64'(iq.almost_full), 64'd0);

    // Fill to full, head stays at pc 0.
    for (int i = 0; i < 8; i++) begin
      offer(32'(i * 4));
      step();
      chk("fill_count", 64'(iq.count), 64'(i + 1));
      chk("fill_af", 64'(iq.almost_full), 64'((i + 1) >= 6));
      chk("fill_full", 64'(iq.full), 64'((i + 1) == 8));
      chk("fill_head", 64'(iq.out_pc), 64'h0);
    end
    offer(32'h20);
    step();
    chk("drop9_count", 64'(iq.count), 64'd8);
    chk("drop9_head", 64'(iq.out_pc), 64'h0);

    // Full + deq + offer: one dequeue only.
    offer(32'h24);
    iq.deq_en = 1'b1;
    step();
    chk("fulldeq_count", 64'(iq.count), 64'd7);
    chk("fulldeq_full", 64'(iq.full), 64'd0);
    chk("fulldeq_head", 64'(iq.out_pc), 64'h4);
    iq.inst_rdy = 1'b0;
    for (int k = 1; k < 8; k++) begin
      chk("drain_pc", 64'(iq.out_pc), 64'(k * 4));
      chk("drain_inst", 64'(iq.out_inst), 64'(32'hA000_0000 | 32'(k * 4)));
      step();
    end
    chk("drain_count", 64'(iq.count), 64'd0);
    chk("drain_valid", 64'(iq.out_valid), 64'd0);

    // Streaming: deq_en on empty is ignored, then steady count 1 across wrap.
    offer(32'h100);
    iq.deq_en = 1'b1;
    step();
    chk("stream0_count", 64'(iq.count), 64'd1);
    chk("stream0_head", 64'(iq.out_pc), 64'h100);
    for (int j = 1; j < 20; j++) begin
      offer(32'h100 + 32'(j * 4));
      step();
      chk("stream_count", 64'(iq.count), 64'd1);
      chk("stream_head", 64'(iq.out_pc), 64'(32'h100 + 32'(j * 4)));
    end
    iq.inst_rdy = 1'b0;
    step();
    chk("stream_end", 64'(iq.count), 64'd0);

    // Flush at count 5 beats enqueue and dequeue.
    idle();
    for (int i = 0; i < 5; i++) begin
      offer(32'h200 + 32'(i * 4));
      step();
    end
    chk("pre_flush", 64'(iq.count), 64'd5);
    offer(32'h300);
    iq.deq_en = 1'b1;
    iq.flush  = 1'b1;
    step();
    idle();
    chk("flush_count", 64'(iq.count), 64'd0);
    chk("flush_valid", 64'(iq.out_valid), 64'd0);
    chk("flush_af", 64'(iq.almost_full), 64'd0);
    offer(32'h304);
    step();
    iq.inst_rdy = 1'b0;
    chk("post_flush_head", 64'(iq.out_pc), 64'h304);
    chk("post_flush_count", 64'(iq.count), 64'd1);
    iq.deq_en = 1'b1;
    step();
    iq.deq_en = 1'b0;
    chk("post_flush_empty", 64'(iq.count), 64'd0);

    // rdy low freezes everything, including flush.
    for (int i = 0; i < 3; i++) begin
      offer(32'h400 + 32'(i * 4));
      step();
    end
    rdy = 1'b0;
    offer(32'h500);
    iq.deq_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      iq.flush = (i == 1);
      step();
      chk("stall_count", 64'(iq.count), 64'd3);
      chk("stall_head", 64'(iq.out_pc), 64'h400);
    end
    rdy = 1'b1;
    iq.flush = 1'b0;
    offer(32'h40C);
    step();
    chk("resume_count", 64'(iq.count), 64'd3);
    chk("resume_head", 64'(iq.out_pc), 64'h404);
    iq.inst_rdy = 1'b0;
    for (int k = 1; k < 4; k++) begin
      chk("resume_drain", 64'(iq.out_pc), 64'(32'h400 + 32'(k * 4)));
      step();
    end
    chk("resume_empty", 64'(iq.count), 64'd0);

    // Asynchronous reset between edges at count 4.
    idle();
    for (int i = 0; i < 4; i++) begin
      offer(32'h600 + 32'(i * 4));
      step();
    end
    iq.inst_rdy = 1'b0;
    chk("pre_rst_count", 64'(iq.count), 64'd4);
    #3 rst = 1'b1;
    #1;
    chk("arst_count", 64'(iq.count), 64'd0);
    chk("arst_valid", 64'(iq.out_valid), 64'd0);
    chk("arst_full", 64'(iq.full), 64'd0);
    chk("arst_af", 64'(iq.almost_full), 64'd0);
    @(posedge clk);
    #2 rst = 1'b0;
    #2;
    offer(32'h40);
    step();
    iq.inst_rdy = 1'b0;
    chk("arst_head", 64'(iq.out_pc), 64'h40);
    chk("arst_newcount", 64'(iq.count), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/inst_queue.md
INST_QUEUE -- requirements
Module: inst_queue

Interface
REQ-001 SHALL have parameter DEPTH_LOG, default 3, log2 of entry count (DEPTH = 2**DEPTH_LOG, legal 1..6).
REQ-002 SHALL have parameter AF_MARGIN, default 2, free-slot margin for almost_full (legal 1..DEPTH-1).
REQ-003 SHALL have parameter INST_W, default 32, width of instruction and PC fields.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 rdy  input  1  global enable; low freezes all state.
REQ-007 inst_rdy  input  1  IFetch presents a valid instruction this cycle.
REQ-008 inst  input  INST_W  fetched instruction word.
REQ-009 pc_in  input  INST_W  PC of fetched instruction.
REQ-010 flush  input  1  branch mispredict / redirect; discard all entries.
REQ-011 deq_en  input  1  consumer (decode/ALU issue) accepts head entry.
REQ-012 out_valid  output  1  head entry valid.
REQ-013 out_inst  output  INST_W  head instruction.
REQ-014 out_pc  output  INST_W  head PC.
REQ-015 full  output  1  count == DEPTH; IFetch must not count on acceptance.
REQ-016 almost_full  output  1  count >= DEPTH - AF_MARGIN; IFetch throttle hint.
REQ-017 count  output  DEPTH_LOG+1  number of valid entries.

Function
REQ-018 SHALL be a circular FIFO with head/tail pointers of DEPTH_LOG bits, wrapping DEPTH-1 -> 0.
REQ-019 Enqueue SHALL occur iff rdy && inst_rdy && !full && !flush; {inst, pc_in} written at tail, tail++.
REQ-020 Dequeue SHALL occur iff rdy && deq_en && out_valid && !flush; head++.
REQ-021 Full SHALL block enqueue even when a dequeue occurs the same cycle; the offered instruction is dropped and IFetch re-presents it.
REQ-022 Simultaneous enqueue and dequeue when 0 < count < DEPTH SHALL leave count unchanged.
REQ-023 Enqueue into empty queue SHALL raise out_valid the next cycle (1-cycle latency); no bypass.
REQ-024 out_inst/out_pc SHALL show head entry combinationally from storage (show-ahead); don't-care when out_valid=0.
REQ-025 deq_en while out_valid=0 SHALL be ignored.
REQ-026 flush SHALL have priority over enqueue and dequeue: next cycle head=tail=0, count=0, out_valid=0.
REQ-027 rdy=0 SHALL hold all pointers, count and storage; flush and rst still not gated? -- flush SHALL be gated by rdy; rst SHALL NOT.
REQ-028 out_valid, full, almost_full SHALL be derived from registered count only.

Reset
REQ-029 On rst high, asynchronously: head=0, tail=0, count=0, out_valid=0, full=0, almost_full=0.
REQ-030 Storage contents SHALL NOT be reset.
REQ-031 rst asserted mid-stream SHALL discard all entries; first enqueue after deassertion lands at index 0.

Structure
REQ-032 Shared package SHALL hold INST_W default and NOP encoding (32'h00000013) used by neighbours.
REQ-033 Storage SHALL be sub-module iq_mem: DEPTH x 2*INST_W array, one synchronous write port, one asynchronous read port.
REQ-034 Pointer/count control SHALL live in inst_queue; no other sub-modules.

Verification (DEPTH_LOG=3, AF_MARGIN=2)
REQ-035 Enqueue 8 instrs (pc 0x00..0x1C) with deq_en=0 -> count 1..8, almost_full at count 6, full at 8; 9th offer dropped, count stays 8.
REQ-036 From full, deq_en=1 and inst_rdy=1 same cycle -> one dequeue, no enqueue, count 7; out_pc order 0x00,0x04,... preserved.
REQ-037 Stream 20 instrs with deq_en=1 each cycle -> count steady at 1, pointers wrap past 7, out_pc sequence contiguous.
REQ-038 count=5, assert flush with inst_rdy=1, deq_en=1 -> next cycle count 0, out_valid 0, flushed instr absent.
REQ-039 rdy=0 for 3 cycles with inst_rdy=1, deq_en=1 -> count/out_pc unchanged; resume correctly.
REQ-040 rst pulse mid-cycle (between edges) at count=4 -> outputs zero immediately; next enqueue pc 0x40 appears as head.
